dlf_pi_gearshift: RTL and testbench

//  Second-generation PLL digital loop filter: explicit proportional + integral paths, fixed-point gains.

---
 rtl/dlf_pkg.sv | 19 +
 rtl/dlf_sat_clamp.sv | 24 ++
 rtl/dlf_pi_gearshift.sv | 185 ++++++++++++++++++
 tb/tb_dlf_pi_gearshift.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlf_pkg.sv
// Shared types and helpers for the PI loop filter with gear shifting.
// Holds the gear enumeration and a width-agnostic signed clamp.
package dlf_pkg;

  typedef enum logic {
    GEAR_ACQ = 1'b0,
    GEAR_TRK = 1'b1
  } gear_e;

  // Callers sign-extend into 64 bits and truncate the result back to their own width.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] val,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/dlf_sat_clamp.sv
// Combinational signed saturation from IN_W down to OUT_W bits, with a clamp flag.
// Bounds default to the full OUT_W signed range; the integrator passes tighter ones.
module dlf_sat_clamp
  import dlf_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10,
  parameter int MIN_V = -(2 ** (OUT_W - 1)),
  parameter int MAX_V = (2 ** (OUT_W - 1)) - 1
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_sat
);

  logic signed [63:0] w_ext;
  logic signed [63:0] w_clamped;

  assign w_ext     = 64'(i_val);
  assign w_clamped = sat_clamp(w_ext, 64'(MIN_V), 64'(MAX_V));
  assign o_val     = w_clamped[OUT_W-1:0];
  assign o_sat     = (w_clamped != w_ext);

endmodule

// File: rtl/dlf_pi_gearshift.sv
// PLL digital loop filter: proportional + clamped integral path, two-stage pipeline,
// with automatic ACQ->TRACK gain-set switching driven by a lock counter.
module dlf_pi_gearshift
  import dlf_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 10,
  parameter int GAIN_W     = 12,
  parameter int FRAC_W     = 6,
  parameter int LOCK_THR   = 2,
  parameter int UNLOCK_THR = 8,
  parameter int LOCK_CNT   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  err,
  input  logic [GAIN_W-1:0]       kp_acq,
  input  logic [GAIN_W-1:0]       ki_acq,
  input  logic [GAIN_W-1:0]       kp_trk,
  input  logic [GAIN_W-1:0]       ki_trk,
  input  logic                    freeze,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] ctrl,
  output logic                    sat,
  output logic                    lock
);

  localparam int PW       = IN_W + GAIN_W + 1;
  localparam int SW       = PW + 1;
  localparam int ACC_W    = OUT_W + FRAC_W;
  localparam int CTRL_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int CTRL_MIN = -(2 ** (OUT_W - 1));
  localparam int CNT_W    = $clog2(LOCK_CNT + 1);

  gear_e              r_gear;
  gear_e              w_gear_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic signed [IN_W:0] w_err_x;
  logic [IN_W:0]        w_abs;
  logic                 w_in_lock;
  logic                 w_unlock;

  // Magnitude in IN_W+1 bits so the most negative error does not wrap.
  assign w_err_x   = (IN_W + 1)'(err);
  assign w_abs     = w_err_x[IN_W] ? unsigned'(-w_err_x) : unsigned'(w_err_x);
  assign w_in_lock = (w_abs <= (IN_W + 1)'(LOCK_THR));
  assign w_unlock  = (w_abs > (IN_W + 1)'(UNLOCK_THR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gear <= GEAR_ACQ;
      r_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      r_gear <= w_gear_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first; a path that leaves a variable unassigned would infer a latch.
    w_gear_nxt = r_gear;
    w_cnt_nxt  = r_cnt;
    if (in_valid && !freeze) begin
      unique case (r_gear)
        GEAR_ACQ: begin
          if (!w_in_lock) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_W'(LOCK_CNT - 1)) begin
            w_gear_nxt = GEAR_TRK;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        GEAR_TRK: begin
          if (w_unlock) begin
            w_gear_nxt = GEAR_ACQ;
            w_cnt_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign lock = (r_gear == GEAR_TRK);

  // Stage 1: products use the gear held before this edge, so a switching sample keeps old gains.
  logic [GAIN_W-1:0]     w_kp;
  logic [GAIN_W-1:0]     w_ki;
  logic signed [PW-1:0]  w_err_p;
  logic signed [PW-1:0]  w_kp_p;
  logic signed [PW-1:0]  w_ki_p;
  logic signed [PW-1:0]  w_p;
  logic signed [PW-1:0]  w_q;
  logic                  r_v1;
  logic signed [PW-1:0]  r_p;
  logic signed [PW-1:0]  r_q;

  assign w_kp    = (r_gear == GEAR_TRK) ? kp_trk : kp_acq;
  assign w_ki    = (r_gear == GEAR_TRK) ? ki_trk : ki_acq;
  assign w_err_p = PW'(err);
  assign w_kp_p  = PW'({1'b0, w_kp});
  assign w_ki_p  = PW'({1'b0, w_ki});
  assign w_p     = w_err_p * w_kp_p;
  assign w_q     = w_err_p * w_ki_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_p  <= '0;
      r_q  <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p <= w_p;
        r_q <= w_q;
      end
    end
  end

  // Stage 2: integrator is clamped to the output range scaled by FRAC_W, so it never winds up.
  logic signed [ACC_W-1:0] r_acc;
  logic signed [SW-1:0]    w_acc_sum;
  logic signed [ACC_W-1:0] w_acc_clamped;
  logic                    w_acc_hit;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [SW-1:0]    w_sum;
  logic signed [SW-1:0]    w_shift;
  logic signed [OUT_W-1:0] w_ctrl;
  logic                    w_sat;

  assign w_acc_sum = SW'(r_acc) + SW'(r_q);

  dlf_sat_clamp #(
    .IN_W (SW),
    .OUT_W(ACC_W),
    .MIN_V(CTRL_MIN * (2 ** FRAC_W)),
    .MAX_V(CTRL_MAX * (2 ** FRAC_W))
  ) u_acc_clamp (
    .i_val(w_acc_sum),
    .o_val(w_acc_clamped),
    .o_sat(w_acc_hit)
  );

  always_comb begin
    w_acc_nxt = r_acc;
    if (!freeze) begin
      w_acc_nxt = w_acc_hit ? w_acc_clamped : w_acc_sum[ACC_W-1:0];
    end
  end

  assign w_sum   = SW'(r_p) + SW'(w_acc_nxt);
  assign w_shift = w_sum >>> FRAC_W;

  dlf_sat_clamp #(
    .IN_W (SW),
    .OUT_W(OUT_W)
  ) u_out_clamp (
    .i_val(w_shift),
    .o_val(w_ctrl),
    .o_sat(w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      ctrl      <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        r_acc <= w_acc_nxt;
        ctrl  <= w_ctrl;
        sat   <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_dlf_pi_gearshift.sv
// Directed self-checking bench for dlf_pi_gearshift; expected values are hand-computed
// with gains in units of 1/64.
module tb_dlf_pi_gearshift;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [7:0]  err;
  logic [11:0]        kp_acq;
  logic [11:0]        ki_acq;
  logic [11:0]        kp_trk;
  logic [11:0]        ki_trk;
  logic               freeze;
  logic               out_valid;
  logic signed [9:0]  ctrl;
  logic               sat;
  logic               lock;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  dlf_pi_gearshift dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .err      (err),
    .kp_acq   (kp_acq),
    .ki_acq   (ki_acq),
    .kp_trk   (kp_trk),
    .ki_trk   (ki_trk),
    .freeze   (freeze),
    .out_valid(out_valid),
    .ctrl     (ctrl),
    .sat      (sat),
    .lock     (lock)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One valid sample, then one idle edge so its result is visible afterwards.
  task automatic pulse(input int e);
    in_valid = 1'b1;
    err      = 8'(e);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    err      = '0;
    freeze   = 1'b0;
    kp_acq   = 12'd64;
    ki_acq   = 12'd0;
    kp_trk   = 12'd128;
    ki_trk   = 12'd0;

    #12;
    check("rst_ctrl", ctrl, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat", sat, 0);
    check("rst_lock", lock, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Proportional only, single sample, two-edge latency.
    in_valid = 1'b1;
    err      = 8'sd5;
    tick();
    in_valid = 1'b0;
    check("t1_not_yet_valid", out_valid, 0);
    tick();
    check("t1_ctrl", ctrl, 5);
    check("t1_out_valid", out_valid, 1);
    check("t1_sat", sat, 0);
    tick();
    check("t1_valid_drops", out_valid, 0);
    check("t1_ctrl_holds", ctrl, 5);

    // Integral ramp: q = 4*32 = 128 per sample -> +2 per step.
    kp_acq   = 12'd0;
    ki_acq   = 12'd32;
    in_valid = 1'b1;
    err      = 8'sd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i > 0) check("t2_ramp", ctrl, 2 * i);
    end
    in_valid = 1'b0;
    tick();
    check("t2_ramp_last", ctrl, 20);
    check("t2_last_valid", out_valid, 1);
    tick();
    check("t2_valid_drops", out_valid, 0);

    // Integrator starts at 1280; +127*64 = 8128 per sample, clamps at 511<<6.
    ki_acq   = 12'd64;
    in_valid = 1'b1;
    err      = 8'sd127;
    tick();
    tick();
    check("t3_acc_step1", ctrl, 147);
    tick();
    tick();
    check("t3_acc_step3", ctrl, 401);
    tick();
    tick();
    check("t3_saturated", ctrl, 511);
    err = -8'sd1;
    tick();
    check("t3_still_511", ctrl, 511);
    err    = 8'sd5;
    kp_acq = 12'd64;
    ki_acq = 12'd0;
    tick();
    check("t3_no_windup", ctrl, 510);
    check("t3_no_windup_sat", sat, 0);
    check("t3_no_windup_valid", out_valid, 1);

    // Asynchronous reset between edges with a sample in flight.
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", ctrl, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_sat", sat, 0);
    check("t5_rst_lock", lock, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_inflight_dropped", out_valid, 0);
    in_valid = 1'b1;
    err      = 8'sd5;
    tick();
    in_valid = 1'b0;
    check("t5_post_latency", out_valid, 0);
    tick();
    check("t5_post_ctrl", ctrl, 5);
    check("t5_post_valid", out_valid, 1);

    // Lock acquisition: 16 in-threshold samples with an idle gap that must not clear the count.
    in_valid = 1'b1;
    err      = 8'sd1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 7) begin
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        in_valid = 1'b1;
      end
    end
    check("t4_not_locked_15", lock, 0);
    err = -8'sd2;
    tick();
    check("t4_locked_16", lock, 1);
    err = 8'sd1;
    tick();
    check("t4_switch_uses_old", ctrl, -2);
    in_valid = 1'b0;
    tick();
    check("t4_trk_gain", ctrl, 2);
    pulse(5);
    check("t4_hyst_5_lock", lock, 1);
    check("t4_hyst_5_ctrl", ctrl, 10);
    pulse(8);
    check("t4_hyst_8_lock", lock, 1);
    check("t4_hyst_8_ctrl", ctrl, 16);
    in_valid = 1'b1;
    err      = 8'sd9;
    tick();
    in_valid = 1'b0;
    check("t4_unlock", lock, 0);
    tick();
    check("t4_unlock_old_gain", ctrl, 18);
    pulse(9);
    check("t4_acq_gain", ctrl, 9);

    // Widest product: -128 * 4095 must not wrap.
    kp_acq = 12'd4095;
    pulse(-128);
    check("t6_neg_sat_ctrl", ctrl, -512);
    check("t6_neg_sat_flag", sat, 1);

    // Freeze holds the integrator while the proportional path still updates.
    kp_acq = 12'd64;
    ki_acq = 12'd64;
    freeze = 1'b1;
    pulse(10);
    check("t6_freeze_p_only", ctrl, 10);
    check("t6_freeze_sat", sat, 0);
    freeze = 1'b0;
    pulse(10);
    check("t6_integrate", ctrl, 20);
    freeze = 1'b1;
    pulse(10);
    check("t6_freeze_hold", ctrl, 20);
    freeze = 1'b0;
    pulse(0);
    check("t6_acc_kept", ctrl, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
